// File: rtl/dlx_pkg.sv
// ---------------------------------------------------------------------------
// dlx_pkg
// Shared DLX definitions used by the fetch unit, its interface and the
// performance counters.
//   DLX_WORD_W    : machine word width (32)
//   dlx_word_t    : one machine word / word address
//   fetch_state_t : fetch sequencer states IDLE / RUN / HALT
//   NOP           : instruction word presented when nothing has been fetched
// ---------------------------------------------------------------------------
package dlx_pkg;

    localparam int DLX_WORD_W = 32;

    typedef logic [DLX_WORD_W-1:0] dlx_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam dlx_word_t NOP = 32'h0000_0000;

endpackage

// File: rtl/dlx_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// dlx_fetch_unit_if
// Bundles the instruction-ROM port, the decode-stage handshake and the
// control inputs of the fetch unit.
//   rom_addr_o    : word address to the instruction ROM
//   rom_data_i    : ROM word for rom_addr_o (combinational, same cycle)
//   ready_i       : decode accepts instr_o/pc_o this cycle
//   redirect_i    : branch/jump taken, reload the PC from redirect_pc_i
//   redirect_pc_i : redirect target word address
//   halt_i        : stop issuing new fetches
//   instr_o       : registered IF/ID instruction
//   pc_o          : registered word address of instr_o
//   valid_o       : instr_o/pc_o hold a live instruction
//   halted_o      : fetch unit is in HALT
// Modports: master = fetch unit side, slave = ROM / decode / control side.
// ---------------------------------------------------------------------------
interface dlx_fetch_unit_if;
    import dlx_pkg::*;

    dlx_word_t rom_addr_o;
    dlx_word_t rom_data_i;
    logic      ready_i;
    logic      redirect_i;
    dlx_word_t redirect_pc_i;
    logic      halt_i;
    dlx_word_t instr_o;
    dlx_word_t pc_o;
    logic      valid_o;
    logic      halted_o;

    modport master (
        output rom_addr_o, instr_o, pc_o, valid_o, halted_o,
        input  rom_data_i, ready_i, redirect_i, redirect_pc_i, halt_i
    );

    modport slave (
        input  rom_addr_o, instr_o, pc_o, valid_o, halted_o,
        output rom_data_i, ready_i, redirect_i, redirect_pc_i, halt_i
    );

endinterface

// File: rtl/dlx_perf_counter.sv
// ---------------------------------------------------------------------------
// dlx_perf_counter
// Free-running 32-bit event counter, wraps modulo 2^32.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset, clears the count
//   inc_i   : add one to the count at the next rising edge
//   count_o : current count
// ---------------------------------------------------------------------------
module dlx_perf_counter
    import dlx_pkg::*;
(
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      inc_i,
    output dlx_word_t count_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (inc_i) begin
            count_o <= count_o + dlx_word_t'(1);
        end
    end

endmodule

// File: rtl/dlx_fetch_unit.sv
// ---------------------------------------------------------------------------
// dlx_fetch_unit
// DLX instruction fetch stage: walks the PC through the instruction ROM,
// registers one instruction per cycle into the IF/ID register and honours
// decode backpressure, redirects (branch/jump) and halt.
//
// Ports:
//   clk_i   : clock, all state updates on the rising edge
//   reset_i : asynchronous active-high reset
//   bus     : dlx_fetch_unit_if.master (ROM port, decode handshake, control)
//   fetch_cnt_o, stall_cnt_o : performance counters, only present when the
//             macro DLX_FETCH_PERF_CNT_EN is defined
//
// Parameter:
//   RESET_PC : word address of the first fetch after reset
//
// Priority per cycle: redirect > halt/stall > normal fetch.
// ---------------------------------------------------------------------------
module dlx_fetch_unit
    import dlx_pkg::*;
#(
    parameter dlx_word_t RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    dlx_fetch_unit_if.master  bus
`ifdef DLX_FETCH_PERF_CNT_EN
    ,
    output dlx_word_t         fetch_cnt_o,
    output dlx_word_t         stall_cnt_o
`endif
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    dlx_word_t pc_reg;
    dlx_word_t instr_reg;
    dlx_word_t pc_out_reg;
    logic      valid_reg;

    // capture: load the IF/ID register from the ROM and advance the PC
    // drain  : HALT hands its last pending instruction to decode
    logic capture;
    logic drain;
    logic halted;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (bus.redirect_i) begin
            // A redirect always restarts fetching, including out of HALT.
            state_next = RUN;
        end else begin
            unique case (state_reg)
                IDLE:    state_next = bus.halt_i ? HALT : RUN;
                RUN:     state_next = bus.halt_i ? HALT : RUN;
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM outputs / datapath controls
    // -----------------------------------------------------------------------
    always_comb begin
        capture = 1'b0;
        drain   = 1'b0;
        halted  = 1'b0;
        if (state_reg == HALT) begin
            halted = 1'b1;
        end
        if (!bus.redirect_i) begin
            // A halt request in RUN does not block this cycle's fetch;
            // HALT is only entered after it.
            if (state_reg == RUN && (!valid_reg || bus.ready_i)) begin
                capture = 1'b1;
            end
            if (state_reg == HALT && valid_reg && bus.ready_i) begin
                drain = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // PC and IF/ID register
    // instr/pc only move on a capture, so decode sees stable data both while
    // stalled and after a redirect kills the held instruction.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_reg     <= RESET_PC;
            instr_reg  <= NOP;
            pc_out_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (bus.redirect_i) begin
            pc_reg    <= bus.redirect_pc_i;
            valid_reg <= 1'b0;
        end else if (capture) begin
            instr_reg  <= bus.rom_data_i;
            pc_out_reg <= pc_reg;
            valid_reg  <= 1'b1;
            pc_reg     <= pc_reg + dlx_word_t'(1);   // wraps modulo 2^32
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.rom_addr_o = pc_reg;
    assign bus.instr_o    = instr_reg;
    assign bus.pc_o       = pc_out_reg;
    assign bus.valid_o    = valid_reg;
    assign bus.halted_o   = halted;

`ifdef DLX_FETCH_PERF_CNT_EN
    // A stall cycle is RUN holding a live instruction that decode refuses.
    logic stall;
    assign stall = (state_reg == RUN) && !bus.redirect_i && valid_reg && !bus.ready_i;

    dlx_perf_counter u_fetch_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (capture),
        .count_o (fetch_cnt_o)
    );

    dlx_perf_counter u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (stall),
        .count_o (stall_cnt_o)
    );
`endif

endmodule

// File: doc/dlx_fetch_unit.md
DLX_FETCH_UNIT -- requirements
Module: dlx_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the word address of the first fetch after reset.
REQ-002 SHALL provide port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_i, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL provide port rom_addr_o, output, 32, the word address driven to the instruction ROM.
REQ-005 SHALL provide port rom_data_i, input, 32, the instruction word returned combinationally by the ROM in the same cycle.
REQ-006 SHALL provide port ready_i, input, 1, decode stage accepts instr_o/pc_o this cycle.
REQ-007 SHALL provide port redirect_i, input, 1, branch/jump taken; load redirect_pc_i.
REQ-008 SHALL provide port redirect_pc_i, input, 32, the redirect target word address.
REQ-009 SHALL provide port halt_i, input, 1, stop issuing new fetches.
REQ-010 SHALL provide port instr_o, output, 32, the registered IF/ID instruction.
REQ-011 SHALL provide port pc_o, output, 32, the registered word address of instr_o.
REQ-012 SHALL provide port valid_o, output, 1, instr_o/pc_o hold a live instruction.
REQ-013 SHALL provide port halted_o, output, 1, high while in HALT.

Function
REQ-014 SHALL implement states IDLE, RUN, HALT; IDLE lasts exactly one cycle after reset release, then RUN.
REQ-015 SHALL drive rom_addr_o = pc_q every cycle.
REQ-016 In RUN with (!valid_o || ready_i), SHALL capture instr_o<=rom_data_i, pc_o<=pc_q, valid_o<=1 and set pc_q<=pc_q+1: one instruction per cycle, latency 1 cycle from address to valid_o.
REQ-017 In RUN with valid_o && !ready_i (stall), SHALL hold pc_q, instr_o, pc_o and valid_o unchanged.
REQ-018 Redirect, when redirect_i=1 in any state, SHALL set pc_q<=redirect_pc_i, valid_o<=0 and state<=RUN.
- Highest priority: overrides halt_i and stall.
- Exits HALT.
- Produces exactly one bubble.
REQ-019 On halt_i=1 without redirect_i, SHALL enter HALT next cycle and issue no further fetches; pc_q holds.
REQ-020 In HALT, a pending valid_o SHALL stay until ready_i=1, then clear to 0.
REQ-021 On a simultaneous halt_i and accepted fetch, the fetch in that cycle SHALL complete, and HALT is entered after it.
REQ-022 pc_q SHALL wrap modulo 2^32 (32'hFFFF_FFFF+1 -> 0) with no error indication.
REQ-023 instr_o and pc_o SHALL change only on a capture, so downstream sees stable data while stalled.

Reset
REQ-024 While reset_i=1, outputs SHALL be pc_q=RESET_PC, rom_addr_o=RESET_PC, instr_o=0, pc_o=0, valid_o=0, halted_o=0, state=IDLE.
REQ-025 Reset asserted mid-operation SHALL discard any held instruction immediately, asynchronously to clk_i.

Configuration
REQ-026 With macro DLX_FETCH_PERF_CNT_EN defined, SHALL add two outputs:
- fetch_cnt_o, 32 bits: increments on each capture.
- stall_cnt_o, 32 bits: increments on each REQ-017 cycle.
- Both reset to 0, both wrap at 2^32.
REQ-027 Without DLX_FETCH_PERF_CNT_EN, these ports and their logic SHALL not exist; all other behaviour is identical.

Structure
REQ-028 Shared package dlx_pkg SHALL hold DLX_WORD_W=32, the fetch state enum (IDLE/RUN/HALT) and the NOP constant 32'h0000_0000.
REQ-029 Counters SHALL be one sub-module, dlx_perf_counter (32-bit, synchronous increment, asynchronous reset), instantiated twice only under DLX_FETCH_PERF_CNT_EN.

Verification
REQ-030 Straight-line fetch: reset, then ready_i=1 held with ROM word 0=32'hFC00_0048 and word 1=32'hFC00_0006 -> cycle 2 after release: instr_o=FC000048, pc_o=0; cycle 3: instr_o=FC000006, pc_o=1.
REQ-031 Backpressure: ready_i=0 for 3 cycles while valid_o=1, pc_o=5 -> instr_o/pc_o/rom_addr_o held (rom_addr_o=6); stall_cnt_o+=3 when enabled.
REQ-032 Redirect during stall: valid_o=1, ready_i=0, redirect_i=1 with redirect_pc_i=32'h0000_000D -> next cycle valid_o=0, rom_addr_o=13; the following cycle pc_o=13.
REQ-033 Halt: halt_i=1 at pc_q=20 with ready_i=0 -> halted_o=1, valid_o held until ready_i=1 then 0, rom_addr_o stays 20; then redirect_i=1 to 0 -> RUN, pc_o=0 two cycles later.
REQ-034 Wrap and async reset: redirect to 32'hFFFF_FFFF -> next pc_o sequence FFFFFFFF, 00000000; asserting reset_i between clock edges -> valid_o=0 immediately.
